// File: rtl/user_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : user_input_conditioner
// Brief    : Synchronise, normalise, debounce and edge-detect raw user inputs;
//            count cycles that carry at least one rising event.
// Revision : 1.0 - initial release
// ============================================================================
module user_input_conditioner #(
  parameter int                    NUM_INPUTS      = 4,
  parameter int                    SYNC_STAGES     = 2,
  parameter int                    DEBOUNCE_CYCLES = 500000,
  parameter logic [NUM_INPUTS-1:0] ACTIVE_LOW_MASK = 4'b1001
) (
  input  logic                  sys_clk,
  input  logic                  sys_reset_n,
  input  logic [NUM_INPUTS-1:0] raw_in,
  output logic [NUM_INPUTS-1:0] clean_out,
  output logic [NUM_INPUTS-1:0] rise_pulse,
  output logic [NUM_INPUTS-1:0] fall_pulse,
  output logic                  any_event,
  output logic [15:0]           event_count,
  input  logic                  count_clear
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync [NUM_INPUTS];
  logic [CNT_W-1:0]       r_cnt  [NUM_INPUTS];
  logic [NUM_INPUTS-1:0]  r_clean;
  logic [NUM_INPUTS-1:0]  r_rise;
  logic [NUM_INPUTS-1:0]  r_fall;
  logic                   r_any;
  logic [15:0]            r_event_count;

  logic [NUM_INPUTS-1:0]  w_s;
  logic [NUM_INPUTS-1:0]  w_differ;
  logic [NUM_INPUTS-1:0]  w_accept;
  logic [NUM_INPUTS-1:0]  w_rise_next;
  logic [NUM_INPUTS-1:0]  w_fall_next;

  // A channel is QUALIFYING while its counter is non-zero; the last
  // consecutive differing sample commits the new level.
  always_comb begin
    w_s      = '0;
    w_differ = '0;
    w_accept = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      w_s[i]      = r_sync[i][SYNC_STAGES-1] ^ ACTIVE_LOW_MASK[i];
      w_differ[i] = w_s[i] ^ r_clean[i];
      w_accept[i] = w_differ[i] && (r_cnt[i] == c_cnt_last);
    end
  end

  assign w_rise_next = w_accept & w_s;
  assign w_fall_next = w_accept & ~w_s;

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        r_sync[i] <= {SYNC_STAGES{ACTIVE_LOW_MASK[i]}};
        r_cnt[i]  <= '0;
      end
      r_clean <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      r_any   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], raw_in[i]};
        if (!w_differ[i] || w_accept[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
      r_clean <= r_clean ^ w_accept;
      r_rise  <= w_rise_next;
      r_fall  <= w_fall_next;
      r_any   <= |(w_rise_next | w_fall_next);
    end
  end

  // Clear wins over a coincident increment; the count sticks at all-ones.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_event_count <= '0;
    end else if (count_clear) begin
      r_event_count <= '0;
    end else if (|r_rise && (r_event_count != 16'hFFFF)) begin
      r_event_count <= r_event_count + 16'd1;
    end
  end

  assign clean_out   = r_clean;
  assign rise_pulse  = r_rise;
  assign fall_pulse  = r_fall;
  assign any_event   = r_any;
  assign event_count = r_event_count;

endmodule
`default_nettype wire

// File: tb/tb_user_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_user_input_conditioner
// Brief    : Self-checking bench; window-based reference model of the debounce.
// Revision : 1.0 - initial release
// ============================================================================
module tb_user_input_conditioner;

  localparam int         N    = 4;
  localparam int         SYNC = 2;
  localparam int         DEB  = 8;
  localparam logic [3:0] MASK = 4'b1001;

  logic        sys_clk     = 1'b0;
  logic        sys_reset_n = 1'b0;
  logic [3:0]  raw_in      = MASK;
  logic        count_clear = 1'b0;
  logic [3:0]  clean_out, rise_pulse, fall_pulse;
  logic        any_event;
  logic [15:0] event_count;

  logic [3:0]  raw_f   = MASK;
  logic        clear_f = 1'b0;
  logic [3:0]  clean_f, rise_f, fall_f;
  logic        any_f;
  logic [15:0] count_f;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 sys_clk = ~sys_clk;

  user_input_conditioner #(
    .NUM_INPUTS(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW_MASK(MASK)
  ) u_dut (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .raw_in(raw_in),
    .clean_out(clean_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .any_event(any_event), .event_count(event_count), .count_clear(count_clear)
  );

  user_input_conditioner #(
    .NUM_INPUTS(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(1), .ACTIVE_LOW_MASK(MASK)
  ) u_fast (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .raw_in(raw_f),
    .clean_out(clean_f), .rise_pulse(rise_f), .fall_pulse(fall_f),
    .any_event(any_f), .event_count(count_f), .count_clear(clear_f)
  );

  // Reference model: a channel flips once its last DEB normalised samples
  // all disagree with the current clean level.
  logic [3:0]     m_pipe0, m_pipe1;
  logic [DEB-1:0] m_win [N];
  logic [3:0]     m_clean, m_rise, m_fall;
  logic           m_any;
  logic [15:0]    m_count;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pipe0 = MASK;
    m_pipe1 = MASK;
    for (int i = 0; i < N; i++) m_win[i] = '0;
    m_clean = '0;
    m_rise  = '0;
    m_fall  = '0;
    m_any   = 1'b0;
    m_count = '0;
  endtask

  task automatic model_step();
    logic [3:0] s;
    if (!sys_reset_n) begin
      model_reset();
      return;
    end
    if (count_clear) m_count = '0;
    else if ((m_rise != 0) && (m_count != 16'hFFFF)) m_count = m_count + 16'd1;
    s      = m_pipe1 ^ MASK;
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < N; i++) begin
      m_win[i] = {m_win[i][DEB-2:0], s[i]};
      if (m_win[i] == {DEB{~m_clean[i]}}) begin
        m_clean[i] = ~m_clean[i];
        if (m_clean[i]) m_rise[i] = 1'b1;
        else            m_fall[i] = 1'b1;
      end
    end
    m_any   = |(m_rise | m_fall);
    m_pipe1 = m_pipe0;
    m_pipe0 = raw_in;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_step();
    @(negedge sys_clk);
    check_eq("clean", clean_out, m_clean);
    check_eq("rise", rise_pulse, m_rise);
    check_eq("fall", fall_pulse, m_fall);
    check_eq("any", any_event, m_any);
    check_eq("count", event_count, m_count);
  endtask

  initial begin
    int lat;
    int hits;
    logic [15:0] c0;

    model_reset();
    repeat (50) tick();
    sys_reset_n = 1'b1;
    repeat (10) tick();

    // Pushbutton press: latency SYNC + DEB from the capture edge.
    raw_in[0] = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (rise_pulse[0] && lat == 0) lat = k;
    end
    check_eq("lat_ch0", lat, SYNC + DEB);
    check_eq("count_after_press", event_count, 1);

    // Bounce: a short burst must not qualify.
    c0 = m_count;
    hits = 0;
    raw_in[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin tick(); hits += int'(rise_pulse[1]); end
    raw_in[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin tick(); hits += int'(rise_pulse[1]); end
    raw_in[1] = 1'b1;
    for (int k = 0; k < 20; k++) begin tick(); hits += int'(rise_pulse[1]); end
    check_eq("bounce_rises", hits, 1);
    check_eq("bounce_count", event_count, 32'(c0) + 1);

    // Two channels rising together count as one event cycle.
    raw_in[2:1] = 2'b00;
    repeat (20) tick();
    c0 = m_count;
    hits = 0;
    raw_in[2:1] = 2'b11;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (rise_pulse[2:1] == 2'b11) hits++;
    end
    check_eq("dual_rise", hits, 1);
    check_eq("dual_count", event_count, 32'(c0) + 1);

    // Randomised levels, bursts and clears.
    for (int r = 0; r < 80; r++) begin
      raw_in      = raw_in ^ 4'($urandom_range(0, 15));
      count_clear = ($urandom_range(0, 7) == 0);
      tick();
      count_clear = 1'b0;
      repeat ($urandom_range(0, 11)) tick();
    end

    // Reset in the middle of qualification, then re-qualify the held level.
    raw_in = MASK;
    repeat (20) tick();
    raw_in[3] = 1'b0;
    repeat (7) tick();
    sys_reset_n = 1'b0;
    model_reset();
    check_eq("async_rst_clean", clean_out, 0);
    repeat (3) tick();
    sys_reset_n = 1'b1;
    lat  = 0;
    hits = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (rise_pulse[3]) begin
        hits++;
        if (lat == 0) lat = k;
      end
    end
    check_eq("rst_lat_ch3", lat, SYNC + DEB);
    check_eq("rst_pulses_ch3", hits, 1);
    check_eq("rst_clean_ch3", clean_out[3], 1);

    // Single-cycle debounce instance: pure synchronise plus edge detect.
    raw_f[2] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (rise_f[2] && lat == 0) lat = k;
    end
    check_eq("fast_lat", lat, SYNC + 1);

    // Out-of-phase toggling of two channels gives a rise every cycle.
    for (int k = 0; k < 65600; k++) begin
      raw_f[0] = ~raw_f[0];
      raw_f[1] = raw_f[0];
      tick();
      if (k == 100) begin
        check_eq("fast_any", any_f, 1);
        check_eq("fast_onehot", $countones(rise_f[1:0]), 1);
      end
    end
    check_eq("sat_count", count_f, 16'hFFFF);
    for (int k = 0; k < 10; k++) begin
      raw_f[0] = ~raw_f[0];
      raw_f[1] = raw_f[0];
      tick();
    end
    check_eq("sat_hold", count_f, 16'hFFFF);
    clear_f  = 1'b1;
    raw_f[0] = ~raw_f[0];
    raw_f[1] = raw_f[0];
    tick();
    check_eq("clear_priority", count_f, 0);
    clear_f  = 1'b0;
    raw_f[0] = ~raw_f[0];
    raw_f[1] = raw_f[0];
    tick();
    check_eq("after_clear", count_f, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
